// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR frame encryptor.
// Holds the FSM state enum, frame constants and the LFSR step function.
package lfsr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    MSG,
    POST,
    DONE
  } lfsr_state_t;

  localparam int         FRAME_LEN = 64;
  localparam logic [7:0] PAD_CHAR  = 8'h20;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] s,
    input logic [7:0] taps
  );
    return {s[6:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit LFSR register: load seed or step once per enabled cycle.
// Ports: clk, rst_n, load, seed, step, taps -> q (current state).
module lfsr8
  import lfsr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  input  logic [7:0] taps,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 8'h00;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_step(q, taps);
    end
  end

endmodule

// File: rtl/lfsr_frame_encryptor.sv
// Pads a plaintext stream to a fixed frame and XORs it with an LFSR.
// Ports: CLK/start_n, cfg_* load, in_* and out_* ready/valid, busy, done.
module lfsr_frame_encryptor #(
  parameter int         FRAME_LEN = 64,
  parameter logic [7:0] PAD_CHAR  = 8'h20
) (
  input  logic       CLK,
  input  logic       start_n,
  input  logic       cfg_load,
  input  logic [7:0] cfg_taps,
  input  logic [7:0] cfg_seed,
  input  logic [5:0] cfg_pre_len,
  input  logic [5:0] cfg_msg_len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  import lfsr_pkg::*;

  localparam logic [6:0] LAST = 7'(FRAME_LEN);

  lfsr_state_t state_q, state_d;

  logic [6:0] idx_q;
  logic [6:0] nidx;
  logic [7:0] taps_q;
  logic [5:0] pre_q;
  logic [5:0] mlen_q;
  logic [6:0] msg_end_q;
  logic [7:0] lfsr_q;
  logic       ov_q;
  logic [7:0] od_q;

  logic       loadable;
  logic       load;
  logic       cfg_take;
  logic [7:0] ld_byte;
  logic       rdy;

  assign loadable = !ov_q || out_ready;
  assign nidx     = idx_q + 7'd1;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    cfg_take = 1'b0;
    ld_byte  = PAD_CHAR;
    rdy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_load) begin
          cfg_take = 1'b1;
          if (cfg_pre_len != 6'd0) begin
            state_d = PRE;
          end else if (cfg_msg_len != 6'd0) begin
            state_d = MSG;
          end else begin
            state_d = POST;
          end
        end
      end
      PRE: begin
        if (loadable) begin
          load = 1'b1;
          if (nidx == {1'b0, pre_q}) begin
            state_d = (mlen_q != 6'd0) ? MSG : POST;
          end
        end
      end
      MSG: begin
        rdy = loadable;
        if (loadable && in_valid) begin
          load    = 1'b1;
          ld_byte = in_data;
          if (nidx == msg_end_q || nidx == LAST) begin
            state_d = POST;
          end
        end
      end
      POST: begin
        // Frame complete once the last byte leaves the register.
        if (idx_q == LAST) begin
          if (loadable) begin
            state_d = DONE;
          end
        end else if (loadable) begin
          load = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      state_q   <= IDLE;
      idx_q     <= 7'd0;
      taps_q    <= 8'h00;
      pre_q     <= 6'd0;
      mlen_q    <= 6'd0;
      msg_end_q <= 7'd0;
      ov_q      <= 1'b0;
      od_q      <= 8'h00;
    end else begin
      state_q <= state_d;
      if (cfg_take) begin
        idx_q     <= 7'd0;
        taps_q    <= cfg_taps;
        pre_q     <= cfg_pre_len;
        mlen_q    <= cfg_msg_len;
        msg_end_q <= 7'(cfg_pre_len) + 7'(cfg_msg_len);
      end else if (load) begin
        idx_q <= nidx;
      end
      if (load) begin
        ov_q <= 1'b1;
        od_q <= ld_byte ^ lfsr_q;
      end else if (ov_q && out_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

  lfsr8 u_lfsr (
    .clk   (CLK),
    .rst_n (start_n),
    .load  (cfg_take),
    .seed  (cfg_seed),
    .step  (load),
    .taps  (taps_q),
    .q     (lfsr_q)
  );

  assign in_ready  = rdy;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_lfsr_frame_encryptor.sv
// Self-checking bench for lfsr_frame_encryptor.
// Frame model built from padding rules plus lfsr_step; literals pin it.
module tb_lfsr_frame_encryptor;
  import lfsr_pkg::*;

  logic       CLK = 1'b0;
  logic       start_n = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_taps = 8'h00;
  logic [7:0] cfg_seed = 8'h00;
  logic [5:0] cfg_pre_len = 6'd0;
  logic [5:0] cfg_msg_len = 6'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       done;

  always #5 CLK = ~CLK;

  lfsr_frame_encryptor dut (
    .CLK         (CLK),
    .start_n     (start_n),
    .cfg_load    (cfg_load),
    .cfg_taps    (cfg_taps),
    .cfg_seed    (cfg_seed),
    .cfg_pre_len (cfg_pre_len),
    .cfg_msg_len (cfg_msg_len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  int total = 0;
  int bad = 0;

  logic [7:0] msg [64];
  logic [7:0] expv[64];
  logic [7:0] got [64];
  int avail, ocnt, cons, dones, exp_cons;
  int stall_at, stall_rem, stall_cyc, first_v, cyc;
  bit noise, prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic set_msg(input string s);
    avail = s.len();
    for (int i = 0; i < 64; i++)
      msg[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  task automatic build(input logic [7:0] taps,
                       input logic [7:0] seed,
                       input int pre, input int mlen);
    logic [7:0] s;
    logic [7:0] p;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      if (i < pre) p = PAD_CHAR;
      else if (i < pre + mlen) p = msg[i - pre];
      else p = PAD_CHAR;
      expv[i] = p ^ s;
      s = lfsr_step(s, taps);
    end
    exp_cons = (pre + mlen > 64) ? 64 - pre : mlen;
  endtask

  task automatic drive();
    in_valid = (cons < avail);
    in_data  = (cons < 64) ? msg[cons] : 8'h00;
    if (ocnt == stall_at && stall_rem > 0) begin
      out_ready = 1'b0;
      stall_rem--;
    end else begin
      out_ready = 1'b1;
    end
    if (noise && (ocnt == 10 || ocnt == 64)) begin
      cfg_load    = 1'b1;
      cfg_seed    = 8'hff;
      cfg_pre_len = 6'd0;
    end else begin
      cfg_load = 1'b0;
    end
  endtask

  task automatic sample();
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
    end
    if (out_valid && out_ready) begin
      if (ocnt < 64) begin
        chk($sformatf("byte%0d", ocnt), out_data, expv[ocnt]);
        got[ocnt] = out_data;
      end else begin
        chk("extra_out", ocnt, 64);
      end
      ocnt++;
    end
    if (out_valid && !out_ready) begin
      stall_cyc++;
      chk("in_ready_stall", in_ready, 0);
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (in_valid && in_ready) cons++;
    if (out_valid && first_v < 0) first_v = cyc;
    if (done) begin
      dones++;
      chk("done_after_64", ocnt, 64);
    end
  endtask

  task automatic run_frame(input logic [7:0] taps,
                           input logic [7:0] seed,
                           input int pre, input int mlen,
                           input int sat, input int slen,
                           input bit nz, input int abort_at);
    bit aborted;
    aborted = 1'b0;
    build(taps, seed, pre, mlen);
    ocnt = 0; cons = 0; dones = 0; stall_cyc = 0;
    stall_at = sat; stall_rem = slen; noise = 1'b0;
    prev_stall = 1'b0; first_v = -1;
    @(posedge CLK); #1;
    cfg_taps = taps; cfg_seed = seed;
    cfg_pre_len = 6'(pre); cfg_msg_len = 6'(mlen);
    cfg_load = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge CLK); #1;
    noise = nz;
    drive();
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      cyc = c;
      sample();
      if (abort_at >= 0 && ocnt >= abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (dones > 0) break;
      @(posedge CLK); #1;
      drive();
    end
    noise = 1'b0;
    if (aborted) begin
      chk("busy_mid", busy, 1);
      #1 start_n = 1'b0;
      #1;
      chk("abort_valid", out_valid, 0);
      chk("abort_data", out_data, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_no_done", dones, 0);
      in_valid = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK) start_n = 1'b1;
    end else begin
      @(posedge CLK); #1;
      cfg_load = 1'b0;
      @(negedge CLK);
      chk("done_count", dones, 1);
      chk("out_count", ocnt, 64);
      chk("consumed", cons, exp_cons);
      chk("first_latency", first_v, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_valid", out_valid, 0);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #1 start_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK) start_n = 1'b1;

    // Nominal frame
    set_msg("The quick brown fox jumps over a lazy cat");
    run_frame(8'hd4, 8'h41, 9, 41, -1, 0, 1'b0, -1);
    chk("t1_b0", got[0], 8'h61);
    chk("t1_b1", got[1], 8'ha3);

    // Zero seed: identity cipher
    set_msg("Mr. Watson, come here. I want to see you.");
    run_frame(8'hd4, 8'h00, 11, 41, -1, 0, 1'b0, -1);
    chk("t2_b0", got[0], 8'h20);
    chk("t2_b10", got[10], 8'h20);
    chk("t2_b11", got[11], 8'h4d);
    chk("t2_b51", got[51], 8'h2e);
    chk("t2_b52", got[52], 8'h20);
    chk("t2_b63", got[63], 8'h20);

    // Backpressure plus ignored cfg_load mid-frame and in DONE
    set_msg("The quick brown fox jumps over a lazy cat");
    run_frame(8'hd4, 8'h5a, 5, 41, 20, 5, 1'b1, -1);
    chk("t3_stall_cycles", stall_cyc, 5);
    repeat (3) begin
      @(negedge CLK);
      chk("t3_stay_idle", busy, 0);
    end

    // Overflow: only 24 plaintext bytes fit
    run_frame(8'h8e, 8'h9c, 40, 41, -1, 0, 1'b0, -1);
    chk("t4_consumed", cons, 24);

    // All padding
    run_frame(8'hb8, 8'h01, 0, 0, -1, 0, 1'b0, -1);
    chk("t5_b0", got[0], 8'h21);
    chk("t5_b1", got[1], 8'h22);

    // Abort mid-frame, then a fresh frame
    run_frame(8'hd4, 8'h41, 9, 41, -1, 0, 1'b0, 30);
    run_frame(8'hd4, 8'h77, 3, 41, -1, 0, 1'b0, -1);
    chk("t6_b0", got[0], 8'h57);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
